// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared defaults and counter sizing for the key event unit
package key_pkg;

  localparam int DEB_CYCLES_DEF = 270_000;
  localparam int REP_DELAY_DEF  = 13_500_000;
  localparam int REP_PERIOD_DEF = 5_400_000;

  // Bits needed for a counter that must hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one key: synchroniser, debounce, press and repeat pulses
// Auto-repeat is built only when KEY_AUTOREPEAT_EN is defined.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int REP_DELAY  = REP_DELAY_DEF,
  parameter int REP_PERIOD = REP_PERIOD_DEF
) (
  input  logic iclk,
  input  logic irst,
  input  logic key_in,
  output logic level,
  output logic press
);

  localparam int DW = cnt_w(DEB_CYCLES);

  logic          sync1;
  logic          s;
  logic [DW-1:0] dc;
  logic          toggle;
  logic          rise;
  logic          rep;

  assign toggle = (s != level) && (dc == DW'(DEB_CYCLES - 1));
  assign rise   = toggle & ~level;

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      dc    <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= key_in;
      s     <= sync1;
      if (s == level) begin
        dc <= '0;
      end else if (toggle) begin
        level <= ~level;
        dc    <= '0;
      end else begin
        dc <= dc + 1'b1;
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW   = cnt_w(RMAX);

  logic [RW-1:0] rc;
  logic [RW-1:0] rc_term;
  logic          rep_phase;
  logic          fall;

  assign fall    = toggle & level;
  // The first interval runs to REP_DELAY, every later one to REP_PERIOD.
  assign rc_term = rep_phase ? RW'(REP_PERIOD - 1) : RW'(REP_DELAY - 1);
  assign rep     = level & ~fall & (rc == rc_term);

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      rc        <= '0;
      rep_phase <= 1'b0;
    end else if (!level || fall) begin
      rc        <= '0;
      rep_phase <= 1'b0;
    end else if (rc == rc_term) begin
      rc        <= '0;
      rep_phase <= 1'b1;
    end else begin
      rc <= rc + 1'b1;
    end
  end
`else
  logic unused_rep_cfg;
  assign unused_rep_cfg = ^{32'(REP_DELAY), 32'(REP_PERIOD)};
  assign rep            = 1'b0;
`endif

  assign press = rise | rep;

endmodule

// File: rtl/key_event_unit.sv
// rtl/key_event_unit.sv - debounced keys to a held valid/ack event register
// Optional auto-repeat per key via KEY_AUTOREPEAT_EN.
module key_event_unit
  import key_pkg::*;
#(
  parameter int W_KEY          = 5,
  parameter int DEB_CYCLES     = DEB_CYCLES_DEF,
  parameter int REP_DELAY      = REP_DELAY_DEF,
  parameter int REP_PERIOD     = REP_PERIOD_DEF,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic [W_KEY-1:0] key_raw,
  output logic [W_KEY-1:0] key_level,
  output logic [W_KEY-1:0] key_evt,
  output logic             evt_valid,
  input  logic             evt_ack,
  output logic             evt_overrun
);

  logic [W_KEY-1:0] press;
  logic [W_KEY-1:0] kept;
  logic [W_KEY-1:0] evt_next;
  logic             ack_taken;

  assign ack_taken = evt_valid & evt_ack;
  assign kept      = key_evt & ~{W_KEY{ack_taken}};
  assign evt_next  = kept | press;

  for (genvar i = 0; i < W_KEY; i++) begin : g_key
    logic key_in;
    assign key_in = (KEY_ACTIVE_LOW != 0) ? ~key_raw[i] : key_raw[i];

    key_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .REP_DELAY  (REP_DELAY),
      .REP_PERIOD (REP_PERIOD)
    ) u_deb (
      .iclk   (iclk),
      .irst   (irst),
      .key_in (key_in),
      .level  (key_level[i]),
      .press  (press[i])
    );
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      key_evt     <= '0;
      evt_valid   <= 1'b0;
      evt_overrun <= 1'b0;
    end else begin
      key_evt   <= evt_next;
      evt_valid <= |evt_next;
      // A press landing on a bit that survives this cycle means one was lost.
      if (|(press & kept)) begin
        evt_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: doc/key_event_unit.md
# key_event_unit

Upstream stage for the LCD1602 keyboard controller. Synchronises and debounces the raw push-button inputs and turns each press into a held event. Held keys optionally auto-repeat. Events are presented to the LCD FSM through a valid/ack handshake, so the slow LCD_EN-clocked consumer cannot miss a single-cycle press.

## Interface
- W_KEY, 5: number of buttons.
- DEB_CYCLES, 270_000: consecutive stable cycles required to accept a level change (10 ms at 27 MHz); legal range ≥ 2.
- REP_DELAY, 13_500_000: cycles from the accepted press to the first repeat (0.5 s).
- REP_PERIOD, 5_400_000: cycles between subsequent repeats (0.2 s); legal range ≥ 1.
- KEY_ACTIVE_LOW, 1: 1 = the raw pin reads 0 when pressed.

Ports:
- iclk, in, 1: system clock.
- irst, in, 1: asynchronous active-low reset.
- key_raw, in, W_KEY: raw button pins, asynchronous to iclk.
- key_level, out, W_KEY: debounced level, 1 = pressed.
- key_evt, out, W_KEY: pending event bits, one per key; valid only while evt_valid is 1.
- evt_valid, out, 1: at least one event is pending.
- evt_ack, in, 1: consumer has taken key_evt. Sampled only while evt_valid is 1.
- evt_overrun, out, 1: sticky flag; some key raised an event while its own key_evt bit was already set and unacknowledged.

## Operation
- Polarity: raw pins are inverted when KEY_ACTIVE_LOW=1, so internally 1 = pressed.
- Per key:
  - Two-flop synchroniser produces s.
  - Debounce counter `dc` counts cycles where s ≠ key_level.
  - `dc` clears on any cycle where s = key_level.
  - When `dc` = DEB_CYCLES-1 and s ≠ key_level, key_level toggles and `dc` clears.
- Press pulse: a one-cycle internal `press[i]` is raised on the edge where key_level[i] goes 0→1.
- Auto-repeat, per key:
  - Repeat counter `rc` clears on press.
  - `rc` counts while key_level=1.
  - At `rc` = REP_DELAY-1, `press[i]` pulses and `rc` reloads to track REP_PERIOD.
  - Thereafter `press[i]` pulses every REP_PERIOD cycles.
  - Release clears `rc` immediately; no repeat is emitted on or after the release edge.
- Event register:
  - key_evt <= (key_evt & ~{W_KEY{ack_taken}}) | press, where ack_taken = evt_valid & evt_ack.
  - evt_valid = |key_evt, registered alongside key_evt.
- Boundary conditions:
  - Simultaneous presses on several keys set several bits in the same cycle.
  - Ack and new press in the same cycle: old bits clear and the new bits are set; evt_valid stays 1.
  - Press on a key whose bit is already set without an ack that cycle: the bit stays 1 and evt_overrun sets. Only irst clears evt_overrun.
  - evt_ack while evt_valid=0 is ignored.
- Counter widths: $clog2(max+1) of the relevant parameter. No wrap: every counter is cleared or reloaded before it can exceed its terminal value.

## Timing
- Reset values: key_level=0, key_evt=0, evt_valid=0, evt_overrun=0. Synchronisers and counters reset to "released", 0.
- Press at raw edge k (input stable after it) gives key_level=1, press and evt_valid=1 at edge k+2+DEB_CYCLES.
- A bounce shorter than DEB_CYCLES produces no change on any output.
- Release latency is the same: 2+DEB_CYCLES.
- First repeat appears REP_DELAY cycles after the press edge. Each later repeat appears REP_PERIOD cycles after the previous one.
- Ack at edge m clears the acknowledged bits at edge m; evt_valid falls at m if no new press arrives.
- Reset asserted mid-debounce or mid-repeat: all state returns to the reset values immediately. A key still held when irst releases is debounced as a new press.

## Configuration
- KEY_AUTOREPEAT_EN defined: repeat counters are instantiated and the behaviour is as above.
- KEY_AUTOREPEAT_EN undefined: no repeat logic. REP_DELAY and REP_PERIOD are unused. Exactly one event per accepted press.

## Structure
- Package key_pkg holds:
  - The default constants: DEB_CYCLES_DEF, REP_DELAY_DEF, REP_PERIOD_DEF.
  - The counter-width helper function.
- Sub-module key_debounce handles one key: synchroniser, debounce, press and repeat generation, with outputs level and press. The top generates W_KEY instances and holds the event register and the overrun flag.

## Test plan
Bench parameters: DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=8, KEY_ACTIVE_LOW=1.
- Clean press: drive key_raw[3] to 0 at cycle 10 → key_level[3]=1 and key_evt=5'b01000, evt_valid=1 at cycle 16. Ack at cycle 18 → evt_valid=0 at cycle 18.
- Bounce: key_raw[1] goes low for 3 cycles, then high → no output change. A hold of 4 cycles followed by a steady hold → one event.
- Auto-repeat: hold key 2 for 60 cycles, acking each event → events at press edge p, then p+20, p+28, p+36, p+44, p+52; none after release. Without the macro, exactly one event.
- Simultaneous and overrun: keys 1 and 2 pressed in the same cycle → key_evt=5'b00110. Re-press key 1 before ack → evt_overrun=1, key_evt unchanged.
- Ack plus new press in the same cycle → key_evt holds only the new bit, evt_valid stays 1.
- Reset mid-operation: assert irst during debounce and during repeat → all outputs return to 0 asynchronously. After release, a still-held key produces a fresh event after 2+DEB_CYCLES cycles.
